// File: rtl/bram_dibit_reader.sv
// Reads a byte range out of the x2 port of an asymmetric BRAM, rebuilds each
// byte from four dibits and streams bytes plus parity over valid/ready.
module bram_dibit_reader #(
  parameter int FIFO_DEPTH = 2,
  parameter bit PAR_ODD    = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [10:0] BASE,
  input  logic [11:0] LEN,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [7:0]  M_DATA,
  output logic        M_PAR,
  output logic        M_VALID,
  input  logic        M_READY,
  output logic [12:0] RAM_ADDR,
  output logic        RAM_EN,
  output logic        RAM_WE,
  input  logic [1:0]  RAM_DO
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t           state;
  logic [10:0]      byte_addr;
  logic [11:0]      remaining;
  logic [1:0]       pending;
  logic             rd_valid;
  logic [1:0]       rd_idx;
  logic [5:0]       assembly;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   occupancy;

  logic             push;
  logic             pop;
  logic             cmd_ok;
  logic             mid_issue;
  logic             can_start;
  logic             start_fetch;
  logic             accept;
  logic [PTR_W+1:0] committed;

  assign RAM_WE    = 1'b0;
  assign push      = rd_valid && (rd_idx == 2'd3);
  assign M_VALID   = (occupancy != '0);
  assign pop       = M_VALID && M_READY;
  assign M_DATA    = M_VALID ? mem[rd_ptr] : 8'h00;
  assign M_PAR     = (^M_DATA) ^ PAR_ODD;
  assign cmd_ok    = (LEN != 12'd0) && (LEN <= 12'd2048);
  assign accept    = (state == IDLE) && START && cmd_ok;
  assign mid_issue = RAM_EN && (RAM_ADDR[1:0] != 2'd3);

  // Bytes already buffered plus bytes still being assembled must leave room
  assign committed   = (PTR_W+2)'(occupancy) + (PTR_W+2)'(pending);
  assign can_start   = committed < (PTR_W+2)'(FIFO_DEPTH);
  assign start_fetch = (state == FETCH) && !mid_issue && (remaining != 12'd0) && can_start;

  assign DONE = (state == DRAIN) && (pending == 2'd0) && (occupancy == (PTR_W+1)'(1)) && M_READY;

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= {RAM_DO, assembly};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      BUSY      <= 1'b0;
      ERR       <= 1'b0;
      RAM_EN    <= 1'b0;
      RAM_ADDR  <= 13'd0;
      byte_addr <= 11'd0;
      remaining <= 12'd0;
      pending   <= 2'd0;
      rd_valid  <= 1'b0;
      rd_idx    <= 2'd0;
      assembly  <= 6'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      ERR       <= 1'b0;
      rd_valid  <= RAM_EN;
      rd_idx    <= RAM_ADDR[1:0];
      pending   <= pending + {1'b0, (accept || start_fetch)} - {1'b0, push};
      occupancy <= occupancy + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (rd_valid && (rd_idx != 2'd3)) begin
        assembly[{rd_idx, 1'b0} +: 2] <= RAM_DO;
      end

      case (state)
        IDLE: begin
          if (START) begin
            if (cmd_ok) begin
              state     <= FETCH;
              BUSY      <= 1'b1;
              RAM_EN    <= 1'b1;
              RAM_ADDR  <= {BASE, 2'b00};
              byte_addr <= BASE + 11'd1;
              remaining <= LEN - 12'd1;
            end else begin
              ERR <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (mid_issue) begin
            RAM_ADDR <= RAM_ADDR + 13'd1;
          end else if (remaining == 12'd0) begin
            RAM_EN <= 1'b0;
            state  <= DRAIN;
          end else if (can_start) begin
            RAM_EN    <= 1'b1;
            RAM_ADDR  <= {byte_addr, 2'b00};
            byte_addr <= byte_addr + 11'd1;
            remaining <= remaining - 12'd1;
          end else begin
            RAM_EN <= 1'b0;
          end
        end
        DRAIN: begin
          if (DONE) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_dibit_reader.sv
// Directed bench for bram_dibit_reader: even and odd parity instances share
// stimulus, each reading its own port of a behavioural dibit RAM.
module tb_bram_dibit_reader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [10:0] BASE;
  logic [11:0] LEN;
  logic        M_READY;

  logic        busy0, done0, err0, m_par0, m_valid0, ram_en0, ram_we0;
  logic [7:0]  m_data0;
  logic [12:0] ram_addr0;
  logic [1:0]  ram_do0;
  logic        busy1, done1, err1, m_par1, m_valid1, ram_en1, ram_we1;
  logic [7:0]  m_data1;
  logic [12:0] ram_addr1;
  logic [1:0]  ram_do1;

  logic [1:0]  ram [8192];

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int start_cyc;
  int addr_log[$];
  int addr_cyc[$];
  int data_log[$];
  int par_log[$];
  int par1_log[$];
  int done_cnt, err_cnt, err_cyc, first_valid_cyc, stab_err;
  logic [7:0] prev_data;
  logic prev_stall = 1'b0;

  always #5 CLK = ~CLK;

  bram_dibit_reader #(.FIFO_DEPTH(2), .PAR_ODD(1'b0)) u_even (
    .CLK(CLK), .RST(RST), .START(START), .BASE(BASE), .LEN(LEN),
    .BUSY(busy0), .DONE(done0), .ERR(err0),
    .M_DATA(m_data0), .M_PAR(m_par0), .M_VALID(m_valid0), .M_READY(M_READY),
    .RAM_ADDR(ram_addr0), .RAM_EN(ram_en0), .RAM_WE(ram_we0), .RAM_DO(ram_do0)
  );

  bram_dibit_reader #(.FIFO_DEPTH(2), .PAR_ODD(1'b1)) u_odd (
    .CLK(CLK), .RST(RST), .START(START), .BASE(BASE), .LEN(LEN),
    .BUSY(busy1), .DONE(done1), .ERR(err1),
    .M_DATA(m_data1), .M_PAR(m_par1), .M_VALID(m_valid1), .M_READY(M_READY),
    .RAM_ADDR(ram_addr1), .RAM_EN(ram_en1), .RAM_WE(ram_we1), .RAM_DO(ram_do1)
  );

  always @(posedge CLK) begin
    if (ram_en0) ram_do0 <= ram[ram_addr0];
    if (ram_en1) ram_do1 <= ram[ram_addr1];
  end

  // Mid-cycle observer: logs RAM issues, handshakes and pulses with cycle stamps
  always @(negedge CLK) begin
    if (ram_en0) begin
      addr_log.push_back(int'(ram_addr0));
      addr_cyc.push_back(cyc);
    end
    if (m_valid0 && M_READY) begin
      data_log.push_back(int'(m_data0));
      par_log.push_back(int'(m_par0));
    end
    if (m_valid1 && M_READY) par1_log.push_back(int'(m_par1));
    if (done0) done_cnt++;
    if (err0) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (m_valid0 && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (prev_stall && (!m_valid0 || m_data0 != prev_data)) stab_err++;
    prev_stall = m_valid0 && !M_READY;
    prev_data  = m_data0;
    cyc++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clearLogs();
    addr_log.delete();
    addr_cyc.delete();
    data_log.delete();
    par_log.delete();
    par1_log.delete();
    done_cnt = 0;
    err_cnt = 0;
    err_cyc = -1;
    first_valid_cyc = -1;
    stab_err = 0;
  endtask

  task automatic loadByte(input int a, input logic [7:0] v);
    for (int k = 0; k < 4; k++) ram[4*a+k] = v[2*k +: 2];
  endtask

  task automatic applyStimulus(input logic [10:0] b, input logic [11:0] l);
    START = 1'b1;
    BASE = b;
    LEN = l;
    start_cyc = cyc;
    tick(1);
    START = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick(1);
    tick(2);
  endtask

  task automatic checkData(input string tag, input int n, input int exp [8]);
    checkOutput({tag, "_count"}, data_log.size(), n);
    for (int i = 0; i < n; i++)
      checkOutput(tag, (i < data_log.size()) ? data_log[i] : -1, exp[i]);
  endtask

  initial begin
    int exp_d [8];
    RST = 1'b1;
    START = 1'b0;
    BASE = '0;
    LEN = '0;
    M_READY = 1'b0;
    for (int i = 0; i < 8192; i++) ram[i] = 2'b00;
    clearLogs();
    tick(2);

    checkOutput("rst_busy", busy0, 0);
    checkOutput("rst_done", done0, 0);
    checkOutput("rst_err", err0, 0);
    checkOutput("rst_valid", m_valid0, 0);
    checkOutput("rst_ram_en", ram_en0, 0);
    checkOutput("rst_ram_addr", ram_addr0, 0);
    checkOutput("rst_data", m_data0, 0);
    checkOutput("rst_par_even", m_par0, 0);
    checkOutput("rst_par_odd", m_par1, 1);
    checkOutput("rst_ram_we", ram_we0, 0);
    RST = 1'b0;
    tick(1);

    // Basic four-byte read with an always-ready consumer
    loadByte(0, 8'hA5);
    loadByte(1, 8'h3C);
    loadByte(2, 8'h00);
    loadByte(3, 8'hFF);
    clearLogs();
    M_READY = 1'b1;
    applyStimulus(11'd0, 12'd4);
    waitDone(100);
    checkOutput("basic_addr_count", addr_log.size(), 16);
    for (int i = 0; i < 16; i++)
      checkOutput("basic_addr", (i < addr_log.size()) ? addr_log[i] : -1, i);
    if (addr_cyc.size() == 16) checkOutput("basic_addr_span", addr_cyc[15] - addr_cyc[0], 15);
    else checkOutput("basic_addr_span", addr_cyc.size(), 16);
    checkOutput("basic_first_en", (addr_cyc.size() > 0) ? addr_cyc[0] - start_cyc : -1, 1);
    checkOutput("basic_first_valid", first_valid_cyc - start_cyc, 6);
    exp_d = '{8'hA5, 8'h3C, 8'h00, 8'hFF, 0, 0, 0, 0};
    checkData("basic_data", 4, exp_d);
    for (int i = 0; i < 4; i++)
      checkOutput("basic_par", (i < par_log.size()) ? par_log[i] : -1, 0);
    checkOutput("basic_done", done_cnt, 1);
    checkOutput("basic_busy_after", busy0, 0);

    // Address wrap from the top of the byte space back to zero
    loadByte(2046, 8'h12);
    loadByte(2047, 8'h34);
    loadByte(0, 8'h56);
    clearLogs();
    applyStimulus(11'd2046, 12'd3);
    waitDone(100);
    checkOutput("wrap_addr_count", addr_log.size(), 12);
    for (int i = 0; i < 12; i++)
      checkOutput("wrap_addr", (i < addr_log.size()) ? addr_log[i] : -1, (i < 8) ? 8184 + i : i - 8);
    exp_d = '{8'h12, 8'h34, 8'h56, 0, 0, 0, 0, 0};
    checkData("wrap_data", 3, exp_d);
    checkOutput("wrap_par1", (par_log.size() > 1) ? par_log[1] : -1, 1);
    checkOutput("wrap_done", done_cnt, 1);

    // Backpressure: consumer stalls, buffer fills, fetching pauses
    loadByte(8, 8'h81);
    loadByte(9, 8'h42);
    loadByte(10, 8'hC3);
    loadByte(11, 8'h24);
    loadByte(12, 8'hE5);
    loadByte(13, 8'h66);
    clearLogs();
    M_READY = 1'b0;
    applyStimulus(11'd8, 12'd6);
    tick(29);
    checkOutput("bp_stall_addr_count", addr_log.size(), 8);
    checkOutput("bp_stall_ram_en", ram_en0, 0);
    checkOutput("bp_stall_valid", m_valid0, 1);
    checkOutput("bp_stall_data", m_data0, 8'h81);
    checkOutput("bp_stall_busy", busy0, 1);
    M_READY = 1'b1;
    waitDone(200);
    exp_d = '{8'h81, 8'h42, 8'hC3, 8'h24, 8'hE5, 8'h66, 0, 0};
    checkData("bp_data", 6, exp_d);
    checkOutput("bp_stable", stab_err, 0);
    checkOutput("bp_addr_count", addr_log.size(), 24);
    checkOutput("bp_done", done_cnt, 1);

    // Rejected commands
    clearLogs();
    applyStimulus(11'd0, 12'd0);
    tick(4);
    checkOutput("rej0_err", err_cnt, 1);
    checkOutput("rej0_err_cycle", err_cyc - start_cyc, 1);
    checkOutput("rej0_no_fetch", addr_log.size(), 0);
    checkOutput("rej0_busy", busy0, 0);
    clearLogs();
    applyStimulus(11'd0, 12'd2049);
    tick(4);
    checkOutput("rej2049_err", err_cnt, 1);
    checkOutput("rej2049_no_fetch", addr_log.size(), 0);
    checkOutput("rej2049_busy", busy0, 0);
    clearLogs();
    applyStimulus(11'd0, 12'd2048);
    tick(1);
    checkOutput("max_len_busy", busy0, 1);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    clearLogs();
    applyStimulus(11'd0, 12'd4);
    tick(2);
    START = 1'b1;
    LEN = 12'd0;
    tick(1);
    START = 1'b0;
    waitDone(100);
    checkOutput("busy_start_err", err_cnt, 0);
    exp_d = '{8'h56, 8'h3C, 8'h00, 8'hFF, 0, 0, 0, 0};
    checkData("busy_start_data", 4, exp_d);
    checkOutput("busy_start_done", done_cnt, 1);

    // Reset in the middle of an eight-byte transfer
    clearLogs();
    applyStimulus(11'd0, 12'd8);
    for (int i = 0; i < 100 && data_log.size() < 2; i++) tick(1);
    RST = 1'b1;
    tick(1);
    checkOutput("midrst_ram_en", ram_en0, 0);
    checkOutput("midrst_valid", m_valid0, 0);
    checkOutput("midrst_busy", busy0, 0);
    checkOutput("midrst_done", done0, 0);
    RST = 1'b0;
    tick(20);
    checkOutput("midrst_no_done", done_cnt, 0);
    clearLogs();
    applyStimulus(11'd0, 12'd1);
    waitDone(100);
    exp_d = '{8'h56, 0, 0, 0, 0, 0, 0, 0};
    checkData("after_rst_data", 1, exp_d);
    checkOutput("after_rst_done", done_cnt, 1);

    // Parity polarity on both instances
    loadByte(100, 8'h01);
    loadByte(101, 8'h03);
    clearLogs();
    applyStimulus(11'd100, 12'd2);
    waitDone(100);
    exp_d = '{8'h01, 8'h03, 0, 0, 0, 0, 0, 0};
    checkData("par_data", 2, exp_d);
    checkOutput("par_even_01", (par_log.size() > 0) ? par_log[0] : -1, 1);
    checkOutput("par_even_03", (par_log.size() > 1) ? par_log[1] : -1, 0);
    checkOutput("par_odd_01", (par1_log.size() > 0) ? par1_log[0] : -1, 0);
    checkOutput("par_odd_03", (par1_log.size() > 1) ? par1_log[1] : -1, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
